// File: rtl/out_fifo_arbiter.sv
// rtl/out_fifo_arbiter.sv - round-robin packet arbiter for the shared output FIFO write port
//
// Purpose:
//   Shares one output FIFO write port among NUM_REQ byte-stream producers.
//   Packets are atomic: a header byte {cmd[2:0], len[4:0]} followed by exactly
//   len payload bytes. Once a requester is granted, the whole packet is moved
//   before any other requester is considered. Grants rotate round-robin.
//   A granted producer that stops supplying bytes mid-packet for
//   STALL_TIMEOUT cycles (with the FIFO able to accept) has its packet
//   aborted, and a sticky error flag is raised.
//
// Ports:
//   clk_i               system clock, forwarded as wr_out_fifo_clk_o
//   reset_n_i           asynchronous active-low reset
//   req_valid_i         per-requester byte valid
//   req_data_i          per-requester byte, requester k on bits [8k+7:8k]
//   req_ready_o         per-requester byte accepted (combinational)
//   wr_out_fifo_clk_o   FIFO write clock (= clk_i)
//   wr_out_fifo_en_o    FIFO write enable (registered)
//   wr_out_fifo_data_o  FIFO write data (registered)
//   wr_out_fifo_full_i  FIFO full
//   wr_out_fifo_afull_i FIFO almost full
//   grant_o             index of the current / most recent grant
//   busy_o              high while a packet is being transferred
//   led_ctrl_err_o      sticky stall-abort flag, cleared only by reset

module out_fifo_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [8*NUM_REQ-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       wr_out_fifo_clk_o,
  output logic                       wr_out_fifo_en_o,
  output logic [7:0]                 wr_out_fifo_data_o,
  input  logic                       wr_out_fifo_full_i,
  input  logic                       wr_out_fifo_afull_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       led_ctrl_err_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t         state_q;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  rr_ptr_q;
  logic           hdr_pending_q;
  logic [4:0]     remaining_q;
  logic [SW-1:0]  stall_cnt_q;
  logic           wr_en_q;
  logic [7:0]     wr_data_q;
  logic           err_q;

  // Per-requester byte lanes as an array so the granted lane is a plain index.
  logic [7:0] req_byte [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign req_byte[g] = req_data_i[8*g +: 8];
  end

  // Round-robin search: first valid index at or above rr_ptr_q, wrapping at
  // NUM_REQ (not at 2**GW, so non-power-of-two counts rotate correctly).
  logic          found;
  logic [GW-1:0] pick;
  logic [GW:0]   cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end
      if (!found && req_valid_i[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  // Almost-full is treated the same as full: the FIFO's write path is
  // registered, so one extra slot of headroom is needed.
  logic          back_pressure;
  logic          cur_valid;
  logic [7:0]    cur_byte;
  logic          beat;
  logic          pkt_done;
  logic          stall_expired;
  logic [GW-1:0] ptr_after_grant;

  assign back_pressure   = wr_out_fifo_full_i | wr_out_fifo_afull_i;
  assign cur_valid       = req_valid_i[grant_q];
  assign cur_byte        = req_byte[grant_q];
  assign beat            = (state_q == XFER) & cur_valid & ~back_pressure;
  assign pkt_done        = hdr_pending_q ? (cur_byte[4:0] == 5'd0) : (remaining_q == 5'd1);
  assign stall_expired   = (stall_cnt_q == SW'(STALL_TIMEOUT - 1));
  assign ptr_after_grant = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    req_ready_o = '0;
    if (state_q == XFER) begin
      req_ready_o[grant_q] = ~back_pressure;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      hdr_pending_q <= 1'b0;
      remaining_q   <= '0;
      stall_cnt_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_q <= 1'b0;
          if (found) begin
            grant_q       <= pick;
            hdr_pending_q <= 1'b1;
            stall_cnt_q   <= '0;
            state_q       <= XFER;
          end
        end

        XFER: begin
          wr_en_q <= beat;
          if (beat) begin
            wr_data_q   <= cur_byte;
            stall_cnt_q <= '0;
            if (hdr_pending_q) begin
              hdr_pending_q <= 1'b0;
              remaining_q   <= cur_byte[4:0];
            end else begin
              remaining_q <= remaining_q - 5'd1;
            end
            if (pkt_done) begin
              state_q  <= IDLE;
              rr_ptr_q <= ptr_after_grant;
            end
          end else if (!back_pressure && !cur_valid) begin
            // Only a producer that could have sent but did not counts as
            // stalling; FIFO back-pressure freezes the counter.
            if (stall_expired) begin
              err_q       <= 1'b1;
              stall_cnt_q <= '0;
              state_q     <= IDLE;
              rr_ptr_q    <= ptr_after_grant;
            end else begin
              stall_cnt_q <= stall_cnt_q + SW'(1);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_out_fifo_clk_o  = clk_i;
  assign wr_out_fifo_en_o   = wr_en_q;
  assign wr_out_fifo_data_o = wr_data_q;
  assign grant_o            = grant_q;
  assign busy_o             = (state_q == XFER);
  assign led_ctrl_err_o     = err_q;

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// tb/tb_out_fifo_arbiter.sv - self-checking bench for out_fifo_arbiter
module tb_out_fifo_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;

  logic            clk_i;
  logic            reset_n_i;
  logic [NR-1:0]   req_valid_i;
  logic [8*NR-1:0] req_data_i;
  logic [NR-1:0]   req_ready_o;
  logic            wr_out_fifo_clk_o;
  logic            wr_out_fifo_en_o;
  logic [7:0]      wr_out_fifo_data_o;
  logic            wr_out_fifo_full_i;
  logic            wr_out_fifo_afull_i;
  logic [1:0]      grant_o;
  logic            busy_o;
  logic            led_ctrl_err_o;

  int total;
  int bad;

  // Per-requester source byte streams, consumed on each handshake.
  logic [7:0]  mem [NR][128];
  int          wr_p [NR];
  int          rd_p [NR];
  logic [NR-1:0] beat_s;

  logic [7:0] out_q [$];
  logic [7:0] exp_q [$];

  out_fifo_arbiter #(
    .NUM_REQ       (NR),
    .STALL_TIMEOUT (TO)
  ) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .req_valid_i         (req_valid_i),
    .req_data_i          (req_data_i),
    .req_ready_o         (req_ready_o),
    .wr_out_fifo_clk_o   (wr_out_fifo_clk_o),
    .wr_out_fifo_en_o    (wr_out_fifo_en_o),
    .wr_out_fifo_data_o  (wr_out_fifo_data_o),
    .wr_out_fifo_full_i  (wr_out_fifo_full_i),
    .wr_out_fifo_afull_i (wr_out_fifo_afull_i),
    .grant_o             (grant_o),
    .busy_o              (busy_o),
    .led_ctrl_err_o      (led_ctrl_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Producers: present the next queued byte; advance after an accepted beat.
  initial begin
    req_valid_i = '0;
    req_data_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (beat_s[k]) rd_p[k]++;
        if (rd_p[k] < wr_p[k]) begin
          req_valid_i[k]         = 1'b1;
          req_data_i[8*k +: 8]   = mem[k][rd_p[k]];
        end else begin
          req_valid_i[k] = 1'b0;
        end
      end
      beat_s = '0;
    end
  end

  // FIFO side: record every write, and latch handshakes for the producers.
  initial begin
    beat_s = '0;
    forever begin
      @(negedge clk_i);
      beat_s = req_valid_i & req_ready_o;
      if (wr_out_fifo_en_o) out_q.push_back(wr_out_fifo_data_o);
    end
  end

  task automatic push_byte(input int k, input logic [7:0] b);
    mem[k][wr_p[k]] = b;
    wr_p[k]++;
  endtask

  task automatic add_pkt(input int k, input logic [7:0] hdr, input logic [7:0] seed);
    push_byte(k, hdr);
    for (int i = 0; i < int'(hdr[4:0]); i++) push_byte(k, seed + 8'(i));
  endtask

  task automatic clear_src();
    for (int k = 0; k < NR; k++) begin
      wr_p[k] = 0;
      rd_p[k] = 0;
    end
    beat_s = '0;
    out_q.delete();
  endtask

  task automatic do_reset();
    reset_n_i           = 1'b0;
    wr_out_fifo_full_i  = 1'b0;
    wr_out_fifo_afull_i = 1'b0;
    clear_src();
    repeat (3) @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
  endtask

  task automatic wait_out(input int n, input int bound);
    for (int c = 0; c < bound && out_q.size() < n; c++) @(posedge clk_i);
    repeat (4) @(posedge clk_i);
    #2;
  endtask

  // Reference: whole packets in round-robin order among requesters that still
  // have packets queued, starting from requester 0 after reset.
  task automatic build_model();
    int p [NR];
    int rr;
    int f;
    int len;
    exp_q.delete();
    for (int k = 0; k < NR; k++) p[k] = 0;
    rr = 0;
    while (1) begin
      f = -1;
      for (int i = 0; i < NR; i++) begin
        if (f < 0 && p[(rr + i) % NR] < wr_p[(rr + i) % NR]) f = (rr + i) % NR;
      end
      if (f < 0) break;
      len = int'(mem[f][p[f]][4:0]);
      for (int j = 0; j <= len; j++) exp_q.push_back(mem[f][p[f] + j]);
      p[f] += len + 1;
      rr = (f + 1) % NR;
    end
  endtask

  task automatic test_reset();
    reset_n_i           = 1'b0;
    wr_out_fifo_full_i  = 1'b0;
    wr_out_fifo_afull_i = 1'b0;
    clear_src();
    repeat (2) @(posedge clk_i);
    #1;
    total += 6;
    if (wr_out_fifo_en_o !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", wr_out_fifo_en_o); end
    if (wr_out_fifo_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", wr_out_fifo_data_o); end
    if (grant_o !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_o); end
    if (led_ctrl_err_o !== 1'b0) begin bad++; $display("FAIL reset_led got=%0b want=0", led_ctrl_err_o); end
    if (req_ready_o !== 3'b000) begin bad++; $display("FAIL reset_ready got=%0b want=000", req_ready_o); end
    #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    add_pkt(1, 8'hE1, 8'h5A);
    for (int c = 0; c < 10 && !req_valid_i[1]; c++) begin @(posedge clk_i); #2; end
    @(posedge clk_i); #1;
    total += 4;
    if (wr_out_fifo_en_o !== 1'b0) begin bad++; $display("FAIL single_arb_en got=%0b want=0", wr_out_fifo_en_o); end
    if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b want=1", busy_o); end
    if (grant_o !== 2'd1) begin bad++; $display("FAIL single_grant got=%0d want=1", grant_o); end
    if (req_ready_o !== 3'b010) begin bad++; $display("FAIL single_ready got=%0b want=010", req_ready_o); end
    @(posedge clk_i); #1;
    total += 2;
    if (wr_out_fifo_en_o !== 1'b1) begin bad++; $display("FAIL single_w1_en got=%0b want=1", wr_out_fifo_en_o); end
    if (wr_out_fifo_data_o !== 8'hE1) begin bad++; $display("FAIL single_w1_data got=%0h want=e1", wr_out_fifo_data_o); end
    @(posedge clk_i); #1;
    total += 3;
    if (wr_out_fifo_en_o !== 1'b1) begin bad++; $display("FAIL single_w2_en got=%0b want=1", wr_out_fifo_en_o); end
    if (wr_out_fifo_data_o !== 8'h5A) begin bad++; $display("FAIL single_w2_data got=%0h want=5a", wr_out_fifo_data_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%0b want=0", busy_o); end
    @(posedge clk_i); #1;
    total += 2;
    if (wr_out_fifo_en_o !== 1'b0) begin bad++; $display("FAIL single_after_en got=%0b want=0", wr_out_fifo_en_o); end
    if (grant_o !== 2'd1) begin bad++; $display("FAIL single_hold_grant got=%0d want=1", grant_o); end
  endtask

  task automatic test_zero_len();
    do_reset();
    add_pkt(0, 8'h40, 8'h00);
    wait_out(1, 20);
    total += 3;
    if (out_q.size() != 1) begin bad++; $display("FAIL zero_count got=%0d want=1", out_q.size()); end
    else if (out_q[0] !== 8'h40) begin bad++; $display("FAIL zero_data got=%0h want=40", out_q[0]); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_busy got=%0b want=0", busy_o); end
    if (grant_o !== 2'd0) begin bad++; $display("FAIL zero_grant got=%0d want=0", grant_o); end
  endtask

  task automatic test_round_robin();
    logic [7:0] hand [8];
    hand = '{8'h21, 8'h00, 8'h21, 8'h01, 8'h21, 8'h02, 8'h21, 8'h00};
    do_reset();
    add_pkt(0, 8'h21, 8'h00);
    add_pkt(0, 8'h21, 8'h00);
    add_pkt(1, 8'h21, 8'h01);
    add_pkt(2, 8'h21, 8'h02);
    wait_out(8, 60);
    total++;
    if (out_q.size() != 8) begin bad++; $display("FAIL rr_count got=%0d want=8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== hand[i]) begin bad++; $display("FAIL rr_byte%0d got=%0h want=%0h", i, out_q[i], hand[i]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] hand [5];
    hand = '{8'h64, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    do_reset();
    add_pkt(0, 8'h64, 8'hC0);
    for (int c = 0; c < 20; c++) begin @(posedge clk_i); #2; if (rd_p[0] >= 3) break; end
    wr_out_fifo_afull_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      total++;
      if (req_ready_o !== 3'b000) begin bad++; $display("FAIL bp_ready cyc%0d got=%0b want=000", i, req_ready_o); end
      if (i > 0) begin
        total++;
        if (wr_out_fifo_en_o !== 1'b0) begin bad++; $display("FAIL bp_en cyc%0d got=%0b want=0", i, wr_out_fifo_en_o); end
      end
    end
    @(posedge clk_i); #2;
    wr_out_fifo_afull_i = 1'b0;
    wait_out(5, 40);
    total += 2;
    if (out_q.size() != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", out_q.size()); end
    if (led_ctrl_err_o !== 1'b0) begin bad++; $display("FAIL bp_led got=%0b want=0", led_ctrl_err_o); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== hand[i]) begin bad++; $display("FAIL bp_byte%0d got=%0h want=%0h", i, out_q[i], hand[i]); end
    end
  endtask

  task automatic test_stall_abort();
    logic [7:0] hand [7];
    int n;
    logic early_led;
    hand = '{8'h63, 8'hA0, 8'h02, 8'h10, 8'h11, 8'h01, 8'h20};
    do_reset();
    push_byte(2, 8'h63);
    push_byte(2, 8'hA0);
    for (int c = 0; c < 20; c++) begin @(posedge clk_i); #2; if (busy_o && grant_o == 2'd2) break; end
    add_pkt(0, 8'h02, 8'h10);
    add_pkt(1, 8'h01, 8'h20);
    for (int c = 0; c < 20; c++) begin if (rd_p[2] >= 2) break; @(posedge clk_i); #2; end
    n = 0;
    early_led = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      n++;
      if (!busy_o) break;
      if (led_ctrl_err_o) early_led = 1'b1;
    end
    total += 3;
    if (n != TO) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", n, TO); end
    if (led_ctrl_err_o !== 1'b1) begin bad++; $display("FAIL stall_led got=%0b want=1", led_ctrl_err_o); end
    if (early_led !== 1'b0) begin bad++; $display("FAIL stall_led_early got=%0b want=0", early_led); end
    wait_out(7, 60);
    total += 3;
    if (out_q.size() != 7) begin bad++; $display("FAIL stall_count got=%0d want=7", out_q.size()); end
    if (led_ctrl_err_o !== 1'b1) begin bad++; $display("FAIL stall_led_sticky got=%0b want=1", led_ctrl_err_o); end
    if (grant_o !== 2'd1) begin bad++; $display("FAIL stall_last_grant got=%0d want=1", grant_o); end
    for (int i = 0; i < 7 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== hand[i]) begin bad++; $display("FAIL stall_byte%0d got=%0h want=%0h", i, out_q[i], hand[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] hand [4];
    hand = '{8'h83, 8'h70, 8'h71, 8'h72};
    total++;
    if (led_ctrl_err_o !== 1'b1) begin bad++; $display("FAIL rmid_led_pre got=%0b want=1", led_ctrl_err_o); end
    add_pkt(1, 8'h2A, 8'h50);
    for (int c = 0; c < 40 && out_q.size() < 3; c++) @(posedge clk_i);
    @(posedge clk_i);
    #3;
    reset_n_i = 1'b0;
    #1;
    total += 4;
    if (wr_out_fifo_en_o !== 1'b0) begin bad++; $display("FAIL rmid_en got=%0b want=0", wr_out_fifo_en_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy_o); end
    if (led_ctrl_err_o !== 1'b0) begin bad++; $display("FAIL rmid_led got=%0b want=0", led_ctrl_err_o); end
    if (grant_o !== 2'd0) begin bad++; $display("FAIL rmid_grant got=%0d want=0", grant_o); end
    clear_src();
    repeat (2) @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
    add_pkt(0, 8'h83, 8'h70);
    wait_out(4, 40);
    total += 2;
    if (out_q.size() != 4) begin bad++; $display("FAIL rmid_count got=%0d want=4", out_q.size()); end
    if (led_ctrl_err_o !== 1'b0) begin bad++; $display("FAIL rmid_led_after got=%0b want=0", led_ctrl_err_o); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== hand[i]) begin bad++; $display("FAIL rmid_byte%0d got=%0h want=%0h", i, out_q[i], hand[i]); end
    end
  endtask

  task automatic test_random();
    int npk;
    logic [7:0] hdr;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int k = 0; k < NR; k++) begin
        npk = $urandom_range(0, 3);
        for (int j = 0; j < npk; j++) begin
          hdr = {3'($urandom), 5'($urandom_range(0, 6))};
          add_pkt(k, hdr, 8'($urandom));
        end
      end
      build_model();
      for (int c = 0; c < 2000 && out_q.size() < exp_q.size(); c++) begin
        @(posedge clk_i);
        #2;
        wr_out_fifo_full_i  = ($urandom % 4 == 0);
        wr_out_fifo_afull_i = ($urandom % 5 == 0);
        @(negedge clk_i);
        if (wr_out_fifo_full_i || wr_out_fifo_afull_i) begin
          total++;
          if (req_ready_o !== 3'b000) begin bad++; $display("FAIL rand%0d_bp_ready got=%0b want=000", it, req_ready_o); end
        end
      end
      @(posedge clk_i); #2;
      wr_out_fifo_full_i  = 1'b0;
      wr_out_fifo_afull_i = 1'b0;
      wait_out(exp_q.size(), 20);
      total += 2;
      if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, out_q.size(), exp_q.size()); end
      if (led_ctrl_err_o !== 1'b0) begin bad++; $display("FAIL rand%0d_led got=%0b want=0", it, led_ctrl_err_o); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
        total++;
        if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d got=%0h want=%0h", it, i, out_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < NR; k++) begin
      wr_p[k] = 0;
      rd_p[k] = 0;
    end
    reset_n_i           = 1'b0;
    wr_out_fifo_full_i  = 1'b0;
    wr_out_fifo_afull_i = 1'b0;
    #3;
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_back_pressure();
    test_stall_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
